l2_arbiter: RTL
===============

Name: l2_arbiter

Overview:
- Shares the single unified L2 cache port between the L1 I-cache miss port and the L1 D-cache miss/writeback port.
- Sits between both L1 controllers and the L2 cache CPU-side interface.
- Grants one requester at a time and latches the granted address, operation and write data.
- Holds the L2 request stable until l2_mem_resp, then routes the response back to the granted side.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cacheline width in bits.
- STARVE_LIMIT, 4, consecutive D grants allowed while I waits; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_mem_read  in  1  I-side line read request.
- i_mem_address  in  ADDR_W  I-side line address.
- i_mem_rdata  out  LINE_W  read line to I-side.
- i_mem_resp  out  1  I-side completion pulse.
- d_mem_read  in  1  D-side line read request.
- d_mem_write  in  1  D-side line write (writeback) request.
- d_mem_address  in  ADDR_W  D-side line address.
- d_mem_wdata  in  LINE_W  D-side write line.
- d_mem_rdata  out  LINE_W  read line to D-side.
- d_mem_resp  out  1  D-side completion pulse.
- l2_mem_read  out  1  read request to L2.
- l2_mem_write  out  1  write request to L2.
- l2_mem_address  out  ADDR_W  latched address to L2.
- l2_mem_wdata  out  LINE_W  latched write line to L2.
- l2_mem_rdata  in  LINE_W  read line from L2.
- l2_mem_resp  in  1  L2 completion.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Reset (rst=0, async):
  - state=IDLE.
  - Latched address, wdata, op and starve counter cleared to 0.
  - All outputs 0: l2_mem_read/write, both resps, all data/address buses.
- Reset mid-transaction: the transaction is abandoned immediately. No response is issued after release. The L1s must reissue.
- IDLE arbitration, evaluated every cycle:
  - Any D request and not starving -> SERVE_D.
  - Else i_mem_read -> SERVE_I.
  - Else stay in IDLE.
  - Default policy is fixed D-over-I priority.
- Grant edge: the granted address, op, and wdata (D write only) are registered.
- SERVE_x outputs:
  - l2_mem_read or l2_mem_write is asserted from the registers the cycle after the request is first seen. Minimum 1-cycle arbitration latency.
  - Requests are held constant until l2_mem_resp.
  - Latched values never change during service, even if requester inputs change.
- Completion:
  - In the cycle l2_mem_resp=1, the granted side's resp=1 combinationally.
  - Its rdata = l2_mem_rdata, passed through for that cycle.
  - Next state = IDLE.
  - The ungranted side's resp stays 0. Its rdata is 0 whenever it is not completing.
- Guaranteed idle cycle: at least one IDLE cycle separates transactions. This prevents double-granting a request the L1 drops on the resp edge.
- A requester that deasserts mid-service does not abort: the L2 op completes and resp is still pulsed.
- d_mem_read and d_mem_write together is a protocol error. Write takes precedence (l2_mem_write=1, l2_mem_read=0).
- l2_mem_read and l2_mem_write are never asserted together. At most one resp is asserted per cycle.

Optional Feature:
- Macro: L2_ARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit saturating counter increments on each D grant made while i_mem_read=1.
  - It clears on any I grant.
  - When the counter equals STARVE_LIMIT, IDLE grants I if i_mem_read=1, even with a D request pending.
- Undefined: strict D priority; the counter is not built; STARVE_LIMIT is ignored.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0; state IDLE after release.
- Single I read, addr 0x00001000, L2 resp after 5 cycles with rdata=0xA5…A5:
  - l2_mem_read=1 and l2_mem_address=0x00001000 from cycle 1 to resp.
  - i_mem_resp pulses once carrying the data; d_mem_resp stays 0.
- Simultaneous I read 0x100 and D write 0x200 (wdata=0x5A…):
  - D is served first: l2_mem_write with address 0x200 and the latched wdata.
  - One IDLE cycle follows, then I read 0x100.
- D changes d_mem_address to 0x300 mid-service -> l2_mem_address stays 0x200 until resp.
- Guard enabled, STARVE_LIMIT=4, D requests back-to-back while I holds 0x100:
  - Exactly 4 D grants occur, then 1 I grant, then D resumes.
  - Guard disabled: I is never granted while D is requesting.
- Reset asserted in SERVE_D before l2_mem_resp -> l2_mem_write drops asynchronously; no d_mem_resp after reset release.

Source files
------------

// File: rtl/l2_arbiter.sv
// Arbitrates the shared L2 port between the L1 I-cache and D-cache miss ports.
// Optional starvation guard: define L2_ARB_STARVE_GUARD_EN.
module l2_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata,
  input  logic [LINE_W-1:0] l2_mem_rdata,
  input  logic              l2_mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              d_req;
  logic              starving;
  logic              grant_d;
  logic              grant_i;

  assign d_req = d_mem_read | d_mem_write;

`ifdef L2_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
  logic [2:0] starve_cnt;

  // Counts D grants that bypassed a waiting I request; saturates at 7.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_mem_read && (starve_cnt != 3'd7)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign starving = i_mem_read && (starve_cnt == STARVE_MAX);
`else
  assign starving = 1'b0;
`endif

  // Grants happen only from IDLE, so every transaction is followed by an idle cycle.
  always_comb begin
    grant_d = (state == IDLE) && d_req && !starving;
    grant_i = (state == IDLE) && !grant_d && i_mem_read;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          next_state = SERVE_D;
        end else if (grant_i) begin
          next_state = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_mem_resp) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Write wins when the D side asserts read and write together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= d_mem_address;
      write_q <= d_mem_write;
      wdata_q <= d_mem_write ? d_mem_wdata : '0;
    end else if (grant_i) begin
      addr_q  <= i_mem_address;
      write_q <= 1'b0;
      wdata_q <= '0;
    end
  end

  always_comb begin
    l2_mem_read    = 1'b0;
    l2_mem_write   = 1'b0;
    l2_mem_address = '0;
    l2_mem_wdata   = '0;
    i_mem_resp     = 1'b0;
    i_mem_rdata    = '0;
    d_mem_resp     = 1'b0;
    d_mem_rdata    = '0;
    if (state != IDLE) begin
      l2_mem_read    = !write_q;
      l2_mem_write   = write_q;
      l2_mem_address = addr_q;
      l2_mem_wdata   = wdata_q;
    end
    if (state == SERVE_I && l2_mem_resp) begin
      i_mem_resp  = 1'b1;
      i_mem_rdata = l2_mem_rdata;
    end
    if (state == SERVE_D && l2_mem_resp) begin
      d_mem_resp  = 1'b1;
      d_mem_rdata = l2_mem_rdata;
    end
  end

endmodule
